arbiter_8_prior: RTL and testbench

//  Sequential 8-requester arbiter that shares one resource among requesters req[7:0].

---
 rtl/arbiter_8_prior_pkg.sv | 18 +
 rtl/arbiter_8_prior_enc.sv | 29 ++
 rtl/arbiter_8_prior.sv | 99 +++++++++
 tb/tb_arbiter_8_prior.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arbiter_8_prior_pkg.sv
// Shared types and constants for the 8-requester priority arbiter.
// Imported by the top and by the rotating priority encoder.
package arbiter_8_prior_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic logic [7:0] onehot8(input logic [2:0] id);
    return 8'b1 << id;
  endfunction

endpackage

// File: rtl/arbiter_8_prior_enc.sv
// Rotating highest-index priority encoder. In round-robin mode the request
// vector is rotated so req[rot-1] is searched first and req[rot] last.
module prio_enc_rot_8x3
  import arbiter_8_prior_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] rot,
  input  logic       mode,
  output logic [2:0] idx,
  output logic       any
);

  logic [2:0] rot_eff;
  logic [7:0] rotated;
  logic [2:0] enc;

  always_comb begin
    rot_eff = (mode == MODE_RR) ? rot : 3'd0;
    // bit j of rotated maps back to req[(j + rot_eff) mod 8]
    rotated = 8'(({req, req}) >> rot_eff);
    enc     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (rotated[i]) enc = 3'(i);
    end
    idx = enc + rot_eff;
    any = |req;
  end

endmodule

// File: rtl/arbiter_8_prior.sv
// 8-requester arbiter: fixed or round-robin priority, grant held while the
// owner keeps requesting, optional forced release after MAX_HOLD cycles.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner, arbitrating every cycle
// ST_GRANT | owner gnt_id holds the resource, hold_cnt counts its cycles
// ST_GAP   | one dead cycle after release, arbitrating for the next owner
module arbiter_8_prior
  import arbiter_8_prior_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

  arb_state_t        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [2:0]        last_id, last_id_nxt;
  logic              preempt_nxt;
  logic [2:0]        win_id;
  logic              win_any;

  prio_enc_rot_8x3 u_enc (
    .req  (req),
    .rot  (last_id),
    .mode (mode),
    .idx  (win_id),
    .any  (win_any)
  );

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    last_id_nxt  = last_id;
    preempt_nxt  = 1'b0;
    case (state)
      ST_IDLE, ST_GAP: begin
        if (win_any) begin
          state_nxt    = ST_GRANT;
          hold_cnt_nxt = HOLD_W'(1);
          last_id_nxt  = win_id;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // owner dropping its request takes precedence over forced release
        if (!req[last_id]) begin
          state_nxt    = ST_GAP;
          hold_cnt_nxt = '0;
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LIM)) begin
          state_nxt    = ST_GAP;
          hold_cnt_nxt = '0;
          preempt_nxt  = 1'b1;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      last_id   <= 3'd0;
      preempt   <= 1'b0;
      gnt       <= 8'd0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      last_id   <= last_id_nxt;
      preempt   <= preempt_nxt;
      gnt       <= (state_nxt == ST_GRANT) ? onehot8(last_id_nxt) : 8'd0;
      gnt_valid <= (state_nxt == ST_GRANT);
    end
  end

  // the last owner index doubles as the mux select and the RR pointer
  assign gnt_id = last_id;

endmodule

// File: tb/tb_arbiter_8_prior.sv
// Directed bench for arbiter_8_prior built with MAX_HOLD=4.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_arbiter_8_prior;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int n_chk;
  int n_err;

  arbiter_8_prior #(.MAX_HOLD(4), .HOLD_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_owner(input string tag, input logic [2:0] id);
    logic [7:0] exp_gnt;
    exp_gnt = 8'h01 << id;
    check_val({tag, " gnt"}, gnt, exp_gnt);
    check_val({tag, " id"}, {5'd0, gnt_id}, {5'd0, id});
    check_val({tag, " valid"}, {7'd0, gnt_valid}, 8'd1);
    check_val({tag, " preempt"}, {7'd0, preempt}, 8'd0);
  endtask

  task automatic check_gap(input string tag, input logic exp_pre);
    check_val({tag, " gnt"}, gnt, 8'h00);
    check_val({tag, " valid"}, {7'd0, gnt_valid}, 8'd0);
    check_val({tag, " preempt"}, {7'd0, preempt}, {7'd0, exp_pre});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    tick(2);
    rst_n = 1'b1;
  endtask

  logic [2:0] rr_seq [9];

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 8'hFF;
    mode  = 1'b0;
    rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    // 1: reset holds outputs low even with all requests up
    tick(3);
    check_gap("rst", 1'b0);
    check_val("rst id", {5'd0, gnt_id}, 8'd0);
    rst_n = 1'b1;
    tick();
    check_owner("first", 3'd7);
    req = 8'h00;
    tick();
    check_gap("first drop", 1'b0);
    tick();

    // 2: fixed priority then hand-over through one gap cycle
    mode = 1'b0;
    req  = 8'b0010_0100;
    tick();
    check_owner("fix5", 3'd5);
    req = 8'b0000_0100;
    tick();
    check_gap("fix gap", 1'b0);
    tick();
    check_owner("fix2", 3'd2);
    req = 8'h00;
    tick(2);

    // 3: round-robin with preemption, all requesting
    do_reset();
    mode = 1'b1;
    req  = 8'hFF;
    tick();
    for (int n = 0; n < 9; n++) begin
      for (int k = 0; k < 4; k++) begin
        check_owner($sformatf("rr%0d c%0d", n, k), rr_seq[n]);
        tick();
      end
      check_gap($sformatf("rr%0d gap", n), 1'b1);
      tick();
    end

    // 4: fixed priority with preemption re-grants 7, never 0
    do_reset();
    mode = 1'b0;
    req  = 8'h81;
    tick();
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 4; k++) begin
        check_owner($sformatf("fx%0d c%0d", n, k), 3'd7);
        tick();
      end
      check_gap($sformatf("fx%0d gap", n), 1'b1);
      tick();
    end

    // 5: owner drops exactly on the hold limit -> no preempt
    check_owner("lim c0", 3'd7);
    tick(3);
    check_owner("lim c3", 3'd7);
    req = 8'h01;
    tick();
    check_gap("lim drop", 1'b0);
    tick();
    check_owner("lim next", 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_gap("async rst", 1'b0);
    check_val("async rst id", {5'd0, gnt_id}, 8'd0);
    tick();
    req = 8'h00;
    rst_n = 1'b1;

    // 6: mode switch mid-grant keeps owner, RR resumes from last_id=3
    mode = 1'b0;
    req  = 8'h08;
    tick();
    check_owner("ms own", 3'd3);
    mode = 1'b1;
    req  = 8'h88;
    tick();
    check_owner("ms keep", 3'd3);
    req = 8'h84;
    tick();
    check_gap("ms gap", 1'b0);
    tick();
    check_owner("ms rr", 3'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
